// File: rtl/alu_issue.sv
// alu_issue
// ---------
// Issue stage between decode and the execution-unit ALU. Accepts decoded
// instruction fields over a valid/ready handshake, translates opcode/funct
// into the 4-bit ALU control code, selects the operands and presents them
// registered to the ALU. A MUL can be held for MUL_CYCLES cycles before it is
// presented, which gives the combinational multiplier a multicycle window.
//
// Configuration macro: ALU_ISSUE_MUL_STALL_EN
//   defined     - MUL waits in MULW for a countdown before out_valid rises.
//   not defined - MUL is issued like ADD/SUB; the MULW state and counter do
//                 not exist and MUL_CYCLES has no effect.
//
// Parameters:
//   MUL_CYCLES   cycles a MUL is held before out_valid (1..15)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset, clears all state
//   flush        synchronous discard of held or pending operation
//   in_valid     decode presents an instruction
//   in_ready     issue can accept this cycle (combinational)
//   opcode       instruction opcode [5:0]
//   funct        R-type function field [5:0]
//   rs_data      first register operand [31:0]
//   rt_data      second register operand [31:0]
//   imm          immediate field [15:0]
//   out_valid    ALUControl/data1/data2 valid for the ALU
//   out_ready    execute stage consumes the operation this cycle
//   ALUControl   ALU control code: ADD=0000, SUB=0001, MUL=0010
//   data1        ALU operand 1
//   data2        ALU operand 2
//   illegal      one-cycle pulse after an undecodable instruction is accepted

module alu_issue #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  ALUControl,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic        illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_MUL    = 6'b011000;

  localparam logic [3:0] CTRL_ADD = 4'b0000;
  localparam logic [3:0] CTRL_SUB = 4'b0001;
  localparam logic [3:0] CTRL_MUL = 4'b0010;

  // Out-of-range MUL_CYCLES would wrap the 4-bit countdown.
  if ((MUL_CYCLES < 1) || (MUL_CYCLES > 15)) begin : g_bad_mul_cycles
    $error("alu_issue: MUL_CYCLES must be in 1..15");
  end

`ifdef ALU_ISSUE_MUL_STALL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    MULW = 2'd2
  } state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  logic [3:0] cnt;
  logic       to_mulw;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1
  } state_t;
`endif

  state_t      state;
  logic        accept;
  logic        dec_ok;
  logic [3:0]  dec_ctrl;
  logic [31:0] dec_d2;

  // A new instruction may enter when the output register is empty, or in the
  // same cycle the held operation drains. Flush blocks acceptance outright.
  assign in_ready = !flush && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  // Opcode/funct translation and operand-2 selection.
  always_comb begin
    dec_ok   = 1'b1;
    dec_ctrl = CTRL_ADD;
    dec_d2   = rt_data;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   dec_ctrl = CTRL_ADD;
          F_SUB:   dec_ctrl = CTRL_SUB;
          F_MUL:   dec_ctrl = CTRL_MUL;
          default: dec_ok   = 1'b0;
        endcase
      end
      OP_ADDI: begin
        dec_ctrl = CTRL_ADD;
        dec_d2   = {{16{imm[15]}}, imm};
      end
      // beq compares by subtraction; the ALU zero flag resolves the branch.
      OP_BEQ:  dec_ctrl = CTRL_SUB;
      default: dec_ok   = 1'b0;
    endcase
  end

`ifdef ALU_ISSUE_MUL_STALL_EN
  // With a single-cycle MUL window the countdown is skipped entirely.
  assign to_mulw = (dec_ctrl == CTRL_MUL) && (MUL_CYCLES > 1);
`endif

  // Issue FSM with registered outputs. Flush wins over every other event;
  // illegal is cleared every cycle so it can only ever be a single pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      ALUControl <= CTRL_ADD;
      data1      <= '0;
      data2      <= '0;
      illegal    <= 1'b0;
`ifdef ALU_ISSUE_MUL_STALL_EN
      cnt        <= '0;
`endif
    end else begin
      illegal <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        out_valid <= 1'b0;
`ifdef ALU_ISSUE_MUL_STALL_EN
        cnt       <= '0;
`endif
      end else begin
        case (state)
          IDLE, HOLD: begin
            if (accept) begin
              if (dec_ok) begin
                ALUControl <= dec_ctrl;
                data1      <= rs_data;
                data2      <= dec_d2;
`ifdef ALU_ISSUE_MUL_STALL_EN
                if (to_mulw) begin
                  state     <= MULW;
                  out_valid <= 1'b0;
                  cnt       <= MUL_LOAD;
                end else begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
                end
`else
                state     <= HOLD;
                out_valid <= 1'b1;
`endif
              end else begin
                illegal   <= 1'b1;
                state     <= IDLE;
                out_valid <= 1'b0;
              end
            end else if ((state == HOLD) && out_ready) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
`ifdef ALU_ISSUE_MUL_STALL_EN
          // The countdown value reaching zero on this edge ends the window.
          MULW: begin
            if (cnt <= 4'd1) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
`endif
          default: begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
// ------------
// Directed testbench for alu_issue. Inputs change on the falling edge, the
// DUT samples on the rising edge, and outputs are compared on the following
// falling edge. Expected values are hand-computed constants.

module tb_alu_issue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ALUControl;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  alu_issue #(.MUL_CYCLES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .funct      (funct),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUControl (ALUControl),
    .data1      (data1),
    .data2      (data2),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of decode-side inputs.
  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [5:0] fn,
                               input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im);
    in_valid = v;
    opcode   = op;
    funct    = fn;
    rs_data  = rs;
    rt_data  = rt;
    imm      = im;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0);
    #12;

    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_ctrl", {28'd0, ALUControl}, 32'd0);
    checkOutput("rst_data1", data1, 32'd0);
    checkOutput("rst_data2", data2, 32'd0);
    checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);

    @(negedge clk);
    reset = 1'b0;

    // add rs=5 rt=7
    applyStimulus(1'b1, 6'b000000, 6'b100000, 32'd5, 32'd7, 16'd0);
    step();
    checkOutput("add_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("add_ctrl", {28'd0, ALUControl}, 32'd0);
    checkOutput("add_data1", data1, 32'd5);
    checkOutput("add_data2", data2, 32'd7);

    // sub accepted while the add drains
    applyStimulus(1'b1, 6'b000000, 6'b100010, 32'd9, 32'd3, 16'd0);
    step();
    checkOutput("sub_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("sub_ctrl", {28'd0, ALUControl}, 32'd1);
    checkOutput("sub_data1", data1, 32'd9);
    checkOutput("sub_data2", data2, 32'd3);

    // addi with negative immediate
    applyStimulus(1'b1, 6'b001000, 6'b000000, 32'd10, 32'h12345678, 16'hFFFE);
    step();
    checkOutput("addi_ctrl", {28'd0, ALUControl}, 32'd0);
    checkOutput("addi_data1", data1, 32'd10);
    checkOutput("addi_data2", data2, 32'hFFFFFFFE);

    // drain to IDLE
    applyStimulus(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0);
    step();
    checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);

    // add held while out_ready is low
    out_ready = 1'b0;
    applyStimulus(1'b1, 6'b000000, 6'b100000, 32'd1, 32'd2, 16'd0);
    step();
    applyStimulus(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("hold_data1", data1, 32'd1);
      checkOutput("hold_data2", data2, 32'd2);
      step();
    end

    // release with a sub presented: no bubble
    out_ready = 1'b1;
    applyStimulus(1'b1, 6'b000000, 6'b100010, 32'd20, 32'd6, 16'd0);
    #1;
    checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    checkOutput("b2b_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("b2b_ctrl", {28'd0, ALUControl}, 32'd1);
    checkOutput("b2b_data1", data1, 32'd20);
    checkOutput("b2b_data2", data2, 32'd6);
    applyStimulus(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0);
    step();

    // illegal opcode pulses one cycle
    applyStimulus(1'b1, 6'b111111, 6'b000000, 32'd1, 32'd1, 16'd0);
    step();
    applyStimulus(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0);
    checkOutput("ill_pulse", {31'd0, illegal}, 32'd1);
    checkOutput("ill_valid", {31'd0, out_valid}, 32'd0);
    step();
    checkOutput("ill_clear", {31'd0, illegal}, 32'd0);
    checkOutput("ill_valid2", {31'd0, out_valid}, 32'd0);

    // flush drops a concurrent beq
    flush = 1'b1;
    applyStimulus(1'b1, 6'b000100, 6'b000000, 32'd4, 32'd4, 16'd0);
    #1;
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0);
    checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_illegal", {31'd0, illegal}, 32'd0);

    // beq issues as SUB
    applyStimulus(1'b1, 6'b000100, 6'b000000, 32'd8, 32'd8, 16'd0);
    step();
    applyStimulus(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0);
    checkOutput("beq_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("beq_ctrl", {28'd0, ALUControl}, 32'd1);
    step();

    // mul rs=3 rt=4
    applyStimulus(1'b1, 6'b000000, 6'b011000, 32'd3, 32'd4, 16'd0);
    step();
    applyStimulus(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0);
`ifdef ALU_ISSUE_MUL_STALL_EN
    for (int i = 0; i < 2; i++) begin
      checkOutput("mulw_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("mulw_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
`endif
    checkOutput("mul_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("mul_ctrl", {28'd0, ALUControl}, 32'd2);
    checkOutput("mul_data1", data1, 32'd3);
    checkOutput("mul_data2", data2, 32'd4);
    step();
    checkOutput("mul_drain", {31'd0, out_valid}, 32'd0);

    // reset shortly after a mul is accepted aborts it
    out_ready = 1'b0;
    applyStimulus(1'b1, 6'b000000, 6'b011000, 32'd6, 32'd7, 16'd0);
    step();
    applyStimulus(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0);
    reset = 1'b1;
    #1;
    checkOutput("rstmul_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstmul_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rstmul_ctrl", {28'd0, ALUControl}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("rstmul_never", {31'd0, out_valid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage driving the execution-unit ALU: accepts decoded instruction fields over a valid/ready handshake, translates opcode/funct into the 4-bit ALU control code, selects operands and presents them registered to the ALU. MUL can be held for a configurable number of cycles so the combinational multiplier gets a multicycle window before its result is consumed. Sits between the decode stage and the ALU as the producer of the ALU's control and operand inputs.

## Interface
- MUL_CYCLES, 3: cycles a MUL is held before `out_valid`; legal range 1–15.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous; discards held or pending operation.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  issue can accept this cycle.
- opcode  input  6  instruction opcode.
- funct  input  6  R-type function field.
- rs_data  input  32  first register operand.
- rt_data  input  32  second register operand.
- imm  input  16  immediate field.
- out_valid  output  1  ALUControl/data1/data2 valid for the ALU.
- out_ready  input  1  execute stage consumes the operation this cycle.
- ALUControl  output  4  ADD=4'b0000, SUB=4'b0001, MUL=4'b0010.
- data1  output  32  ALU operand 1.
- data2  output  32  ALU operand 2.
- illegal  output  1  one-cycle pulse: accepted instruction not decodable.

## Operation
- Decode (on accept, `in_valid && in_ready`):
  - opcode 000000, funct 100000 → ADD, data1=rs_data, data2=rt_data.
  - opcode 000000, funct 100010 → SUB, rs/rt.
  - opcode 000000, funct 011000 → MUL, rs/rt.
  - opcode 001000 (addi) → ADD, data1=rs_data, data2=sign-extended imm (bit 15 replicated into [31:16]).
  - opcode 000100 (beq) → SUB, rs/rt (the ALU's zero flag resolves the branch).
  - anything else → instruction consumed, nothing issued, `illegal` high for the next cycle only.
- States: IDLE (output empty), HOLD (output valid, waiting for `out_ready`), MULW (MUL captured, countdown running, `out_valid` low).
- IDLE: `in_ready`=1. Accepting ADD/SUB → HOLD. Accepting MUL → MULW with counter=MUL_CYCLES-1, or HOLD if MUL_CYCLES=1. Accepting illegal → stays IDLE.
- MULW: `in_ready`=0. Counter decrements each cycle; at 0 → HOLD.
- HOLD: `out_valid`=1. `ALUControl`, `data1` and `data2` stay stable until `out_ready`. `in_ready`=`out_ready`, so a new instruction is accepted in the same cycle the held one drains (back-to-back, no bubble). `out_ready` with no accept → IDLE.
- Flush overrides everything: next state IDLE, `out_valid` 0, `in_ready` forced 0 in the flush cycle, and any concurrent input is dropped without raising `illegal`.
- Operand values are passed unchanged; no arithmetic is performed here beyond sign extension.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, `ALUControl`=4'b0000, `data1`=0, `data2`=0, `illegal`=0, state IDLE, counter 0.
- Reset asserted mid-MULW or mid-HOLD: the operation is aborted immediately and never issued.
- ADD/SUB latency: accepted at edge k → `out_valid` high after edge k.
- MUL latency (macro defined): accepted at edge k → `out_valid` high after edge k+MUL_CYCLES-1.
- `illegal`: high after the accept edge, low one edge later.
- All outputs are registered except `in_ready`, which is combinational from state, `out_ready` and `flush`.

## Configuration
- ALU_ISSUE_MUL_STALL_EN defined: MUL goes through MULW as specified above.
- Not defined: MUL behaves exactly like ADD/SUB (IDLE→HOLD, 1-cycle latency). MUL_CYCLES is ignored and the MULW state and counter are not synthesized.

## Test plan
- Reset, then add with rs=5, rt=7, `out_ready`=1 → next cycle `out_valid`=1, ALUControl=0000, data1=5, data2=7. Same for sub → 0001.
- addi with imm=16'hFFFE, rs=10 → data2=32'hFFFFFFFE, ALUControl=0000.
- Macro on, MUL_CYCLES=3, mult rs=3, rt=4 → `out_valid` low for 2 cycles after accept, then high with ALUControl=0010; `in_ready`=0 throughout MULW.
- `out_ready`=0 for 4 cycles with an add held → outputs stable and `in_ready`=0. Raise `out_ready` while `in_valid` presents sub → sub appears next cycle with no bubble.
- opcode 6'b111111 → `illegal` pulses exactly one cycle, `out_valid` stays 0. Flush in the same cycle as a valid beq → beq dropped, `in_ready`=0 that cycle.
- Reset asserted during MULW → `out_valid` 0 and state IDLE immediately. Repeat with the macro off → MUL issues after 1 cycle.
